uart_rx_ext: RTL and testbench
==============================

# uart_rx_ext

Configurable UART receiver with runtime frame format (5..DATA_WIDTH data bits, none/even/odd parity, 1 or 2 stop bits), 3-sample majority-vote bit detection, break detection and an integrated show-ahead FIFO that stores per-frame error flags alongside data. It sits between the asynchronous `rxd` pin and the AXI-Lite register block, which pops frames through a valid/ready handshake and reads sticky line-status errors.

## Interface
- `DATA_WIDTH`, 8: maximum data bits per frame; legal 5..9.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, >= 2.
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input, idle high.
- `prescale`  in  16  clocks per bit; values < 4 are treated as 4.
- `data_bits`  in  4  data bits per frame; values outside 5..DATA_WIDTH are treated as DATA_WIDTH.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `rx_data`  out  DATA_WIDTH  head-of-FIFO data, right-justified, unused upper bits 0.
- `rx_parity_err`  out  1  head entry parity-error flag.
- `rx_frame_err`  out  1  head entry framing-error flag.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head entry.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- `busy`  out  1  receiver FSM not in IDLE.
- `overrun_error`  out  1  sticky: frame dropped because the FIFO was full.
- `break_detect`  out  1  sticky: break condition seen.
- `clear_errors`  in  1  single-cycle pulse that clears both sticky flags.

## Operation
- `rxd` passes through a 2-FF synchronizer (reset value 1); all logic uses the synchronized `rxd_s`.
- `prescale`, `data_bits`, `parity_mode` and `stop_bits` are latched on start detection. Changes mid-frame have no effect until the next frame.
- Bit decision: a down-counter is loaded with the bit period minus 1. `rxd_s` is sampled when the counter is 2, 1 and 0; the bit value is the majority of the three samples.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
  - IDLE: when `rxd_s` is 0, latch the config, load the counter with (prescale>>1)-1 and go to START.
  - START: on majority 1 (false start), return to IDLE with no flags and no write. Otherwise load prescale-1 and go to DATA.
  - DATA: shift bits in LSB first, `data_bits` bits total. Then go to PARITY if parity is enabled, else STOP1.
  - PARITY: error if the received bit differs from the expected bit. Even mode expects the XOR of the data bits; odd mode expects its inverse.
  - STOP1: framing error if the bit is 0. Go to STOP2 if `stop_bits` is 1, else end the frame.
  - STOP2: framing error if the bit is 0; end the frame.
- Frame end:
  - Break: data, parity (if enabled) and STOP1 are all 0. Set `break_detect`, write nothing, go to BREAK. BREAK waits for `rxd_s` to be 1, then goes to IDLE.
  - Otherwise push {data, parity_err, frame_err} to the FIFO. Frames with errors are still stored, with their flags set.
  - FIFO full at push time: drop the frame and set `overrun_error`. A pop in the same cycle frees a slot first: the push succeeds and the level is unchanged.
- FIFO is show-ahead. `rx_data` and the flags are valid whenever `rx_valid` is 1. A pop occurs when `rx_valid && rx_ready`. Pointers wrap modulo FIFO_DEPTH. Reading while empty has no effect.
- `clear_errors` clears the sticky flags. If a set event occurs in the same cycle, set wins.

## Timing
- Reset: state IDLE; FIFO empty; `rx_valid`, `rx_data`, `rx_parity_err`, `rx_frame_err`, `fifo_level`, `busy`, `overrun_error` and `break_detect` are all 0.
- `busy` rises the cycle after `rxd_s` is first seen low. It falls the cycle after the final stop-bit sample, or after BREAK exits.
- `rxd` falling edge to START entry: 3 cycles (2 synchronizer + 1 FSM).
- FIFO push occurs in the cycle after the final stop-bit decision. `rx_valid` and the incremented `fifo_level` are visible the following cycle.
- Pop: the head advances and `fifo_level` decrements in the cycle after the `rx_valid && rx_ready` edge.
- Sticky flags assert in the cycle after the deciding sample.
- Reset mid-frame aborts the frame, empties the FIFO and clears all flags. No partial frame is written.

## Test plan
- 8N1, prescale 16, send 0xA5 then 0x3C with `rx_ready`=0 -> `fifo_level`=2, head 0xA5 with both error flags 0; pop -> head 0x3C.
- 7E2, prescale 8, send 0x55 with a wrong parity bit -> entry 0x55, `rx_parity_err`=1, `rx_frame_err`=0. Send a frame with stop2=0 -> `rx_frame_err`=1.
- Single-cycle low glitch on `rxd` -> false start: no entry, `busy` returns to 0, no flags. One-sample glitch in mid-bit of 0x0F -> majority vote still yields 0x0F.
- Hold `rxd` low for 12 bit times (8N1) -> `break_detect`=1, no FIFO write, FSM in BREAK until `rxd` goes high. Pulse `clear_errors` -> flag returns to 0.
- FIFO_DEPTH=4, send 5 frames without popping -> `fifo_level`=4, `overrun_error`=1, the first 4 frames are intact. Repeat with `rx_ready`=1 during the 5th push -> no overrun, level stays 4.
- Change `data_bits` from 8 to 5 mid-frame -> the current frame still carries 8 bits. The next frame 0x1F is received as 5 bits with upper bits 0.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext
// -----------
// UART receiver with a frame format chosen at run time. A frame has 5..DATA_WIDTH
// data bits, optional even or odd parity, and one or two stop bits. Each bit is
// decided by a 3-sample majority vote taken around the middle of the bit. The
// receiver also detects a break on the line. Received frames go into a show-ahead
// FIFO, and each entry keeps its own parity-error and framing-error flags.
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   rxd              asynchronous serial input, idle high
//   prescale         clocks per bit (values below 4 behave as 4)
//   data_bits        data bits per frame (out-of-range values behave as DATA_WIDTH)
//   parity_mode      00/11 none, 01 even, 10 odd
//   stop_bits        0 = one stop bit, 1 = two stop bits
//   rx_data          head-of-FIFO data, right-justified
//   rx_parity_err    head entry parity-error flag
//   rx_frame_err     head entry framing-error flag
//   rx_valid         FIFO holds at least one entry
//   rx_ready         consumer accepts the head entry this cycle
//   fifo_level       number of stored entries
//   busy             receiver is inside a frame or waiting out a break
//   overrun_error    sticky: a frame was dropped because the FIFO was full
//   break_detect     sticky: a break condition was seen
//   clear_errors     one-cycle pulse that clears both sticky flags

module uart_rx_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic [15:0]                   prescale,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overrun_error,
  output logic                          break_detect,
  input  logic                          clear_errors
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK
  } state_t;

  // Synchronizer and sample history
  logic       rxd_meta_q, rxd_meta_d;
  logic       rxd_s_q, rxd_s_d;
  logic [1:0] hist_q, hist_d;

  // Receiver FSM and datapath
  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             cfg_prescale_q, cfg_prescale_d;
  logic [3:0]              cfg_bits_q, cfg_bits_d;
  logic                    cfg_par_en_q, cfg_par_en_d;
  logic                    cfg_par_odd_q, cfg_par_odd_d;
  logic                    cfg_two_stop_q, cfg_two_stop_d;
  logic [3:0]              bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_acc_q, par_acc_d;
  logic                    all_zero_q, all_zero_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;

  // Completed frame waiting to be written into the FIFO
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   push_data_q, push_data_d;
  logic                    push_perr_q, push_perr_d;
  logic                    push_ferr_q, push_ferr_d;

  // FIFO
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [EW-1:0]           head_entry;
  logic                    fifo_full;
  logic                    pop;
  logic                    wr_en;
  logic                    overrun_set;

  // Sticky flags
  logic                    overrun_q, overrun_d;
  logic                    break_q, break_d;
  logic                    break_set;

  // Derived values
  logic                    bit_maj;
  logic                    sample_now;
  logic [15:0]             prescale_eff;
  logic [3:0]              bits_eff;

  // Two-flop synchronizer for rxd. Behind it sits a two-deep history of rxd_s.
  // When the counter reaches 0, hist_q holds the samples taken at counts 2 and 1.
  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
    hist_d     = {hist_q[0], rxd_s_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      hist_q     <= 2'b11;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
      hist_q     <= hist_d;
    end
  end

  // The bit value is the majority of the three samples at counts 2, 1 and 0.
  assign bit_maj    = (rxd_s_q & hist_q[0]) | (rxd_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign sample_now = (cnt_q == 16'd0);

  // Clamp the run-time configuration before it is latched at start detection.
  assign prescale_eff = (prescale < 16'd4) ? 16'd4 : prescale;
  assign bits_eff     = ((data_bits >= 4'd5) && (data_bits <= 4'(DATA_WIDTH)))
                        ? data_bits : 4'(DATA_WIDTH);

  // Receiver next-state logic. Every bit state waits for the counter to reach 0,
  // takes the majority decision, and then reloads the counter for the next bit.
  // all_zero_q tracks whether every data bit and the parity bit were 0. If STOP1
  // is also 0, the frame is treated as a break rather than a framing error.
  always_comb begin
    state_d        = state_q;
    cnt_d          = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : cnt_q;
    cfg_prescale_d = cfg_prescale_q;
    cfg_bits_d     = cfg_bits_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_odd_d  = cfg_par_odd_q;
    cfg_two_stop_d = cfg_two_stop_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    par_acc_d      = par_acc_q;
    all_zero_d     = all_zero_q;
    perr_d         = perr_q;
    ferr_d         = ferr_q;
    push_d         = 1'b0;
    push_data_d    = push_data_q;
    push_perr_d    = push_perr_q;
    push_ferr_d    = push_ferr_q;
    break_set      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxd_s_q) begin
          cfg_prescale_d = prescale_eff;
          cfg_bits_d     = bits_eff;
          cfg_par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          cfg_par_odd_d  = (parity_mode == 2'b10);
          cfg_two_stop_d = stop_bits;
          cnt_d          = (prescale_eff >> 1) - 16'd1;
          bit_idx_d      = 4'd0;
          shift_d        = '0;
          par_acc_d      = 1'b0;
          all_zero_d     = 1'b1;
          perr_d         = 1'b0;
          ferr_d         = 1'b0;
          state_d        = ST_START;
        end
      end

      ST_START: begin
        if (sample_now) begin
          if (bit_maj) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cfg_prescale_q - 16'd1;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (sample_now) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_idx_q == 4'(i)) begin
              shift_d[i] = bit_maj;
            end
          end
          par_acc_d = par_acc_q ^ bit_maj;
          if (bit_maj) begin
            all_zero_d = 1'b0;
          end
          cnt_d = cfg_prescale_q - 16'd1;
          if (bit_idx_q == (cfg_bits_q - 4'd1)) begin
            state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (sample_now) begin
          perr_d = bit_maj ^ (par_acc_q ^ cfg_par_odd_q);
          if (bit_maj) begin
            all_zero_d = 1'b0;
          end
          cnt_d   = cfg_prescale_q - 16'd1;
          state_d = ST_STOP1;
        end
      end

      ST_STOP1: begin
        if (sample_now) begin
          if (!bit_maj && all_zero_q) begin
            break_set = 1'b1;
            state_d   = ST_BREAK;
          end else if (cfg_two_stop_q) begin
            ferr_d  = ferr_q | ~bit_maj;
            cnt_d   = cfg_prescale_q - 16'd1;
            state_d = ST_STOP2;
          end else begin
            push_d      = 1'b1;
            push_data_d = shift_q;
            push_perr_d = perr_q;
            push_ferr_d = ferr_q | ~bit_maj;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_STOP2: begin
        if (sample_now) begin
          push_d      = 1'b1;
          push_data_d = shift_q;
          push_perr_d = perr_q;
          push_ferr_d = ferr_q | ~bit_maj;
          state_d     = ST_IDLE;
        end
      end

      ST_BREAK: begin
        if (rxd_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 16'd0;
      cfg_prescale_q <= 16'd4;
      cfg_bits_q     <= 4'(DATA_WIDTH);
      cfg_par_en_q   <= 1'b0;
      cfg_par_odd_q  <= 1'b0;
      cfg_two_stop_q <= 1'b0;
      bit_idx_q      <= 4'd0;
      shift_q        <= '0;
      par_acc_q      <= 1'b0;
      all_zero_q     <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      push_q         <= 1'b0;
      push_data_q    <= '0;
      push_perr_q    <= 1'b0;
      push_ferr_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cfg_prescale_q <= cfg_prescale_d;
      cfg_bits_q     <= cfg_bits_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_odd_q  <= cfg_par_odd_d;
      cfg_two_stop_q <= cfg_two_stop_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      par_acc_q      <= par_acc_d;
      all_zero_q     <= all_zero_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      push_q         <= push_d;
      push_data_q    <= push_data_d;
      push_perr_q    <= push_perr_d;
      push_ferr_q    <= push_ferr_d;
    end
  end

  // FIFO control. If the FIFO is full, a pop in the same cycle frees a slot, so
  // the pending frame is still written. A frame is dropped only when the FIFO is
  // full and nothing is popped.
  assign rx_valid    = (level_q != '0);
  assign pop         = rx_valid && rx_ready;
  assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
  assign wr_en       = push_q && (!fifo_full || pop);
  assign overrun_set = push_q && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    level_d  = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // The storage array is not reset. The head outputs are masked while the FIFO
  // is empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {push_data_q, push_perr_q, push_ferr_q};
    end
  end

  assign head_entry = mem_q[rd_ptr_q];

  // Sticky line-status flags. A set event in the same cycle overrides clear_errors.
  always_comb begin
    overrun_d = overrun_set | (overrun_q & ~clear_errors);
    break_d   = break_set   | (break_q   & ~clear_errors);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      break_q   <= break_d;
    end
  end

  assign rx_data       = rx_valid ? head_entry[EW-1:2] : '0;
  assign rx_parity_err = rx_valid & head_entry[1];
  assign rx_frame_err  = rx_valid & head_entry[0];
  assign fifo_level    = level_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun_error = overrun_q;
  assign break_detect  = break_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext
// --------------
// Directed testbench for uart_rx_ext. It uses a 4-entry FIFO so that overrun is
// easy to reach. Frames are driven on rxd at falling clock edges. Outputs are
// compared at falling edges against values worked out by hand for each frame.

module tb_uart_rx_ext;

  localparam int DW = 8;
  localparam int FD = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rxd;
  logic [15:0]            prescale;
  logic [3:0]             data_bits;
  logic [1:0]             parity_mode;
  logic                   stop_bits;
  logic [DW-1:0]          rx_data;
  logic                   rx_parity_err;
  logic                   rx_frame_err;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [$clog2(FD):0]    fifo_level;
  logic                   busy;
  logic                   overrun_error;
  logic                   break_detect;
  logic                   clear_errors;

  int errorCount = 0;
  int checkCount = 0;

  uart_rx_ext #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .prescale     (prescale),
    .data_bits    (data_bits),
    .parity_mode  (parity_mode),
    .stop_bits    (stop_bits),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .overrun_error(overrun_error),
    .break_detect (break_detect),
    .clear_errors (clear_errors)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through this task.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one bit for p clocks. If glitch is set, the bit is inverted for one
  // clock in the middle of the bit.
  task automatic sendBit(input logic b, input int p, input bit glitch);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      rxd = (glitch && (c == (p / 2 - 1))) ? ~b : b;
    end
  endtask

  // Sends one frame: the start bit, nbits data bits LSB first, a parity bit when
  // parMode is 1 (even) or 2 (odd), a stop bit of 1, and an optional second stop
  // bit stop2Val. After the frame, rxd idles high for one bit time.
  task automatic applyStimulus(input logic [8:0] data, input int nbits, input int parMode,
                               input bit parFlip, input logic stop2Val, input int nstop,
                               input int p, input int glitchBit);
    logic par;
    par = 1'b0;
    sendBit(1'b0, p, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      sendBit(data[i], p, glitchBit == i);
      par = par ^ data[i];
    end
    if (parMode == 1 || parMode == 2) begin
      if (parMode == 2) par = ~par;
      sendBit(par ^ parFlip, p, 1'b0);
    end
    sendBit(1'b1, p, 1'b0);
    if (nstop == 2) sendBit(stop2Val, p, 1'b0);
    sendBit(1'b1, p, 1'b0);
  endtask

  task automatic setConfig(input logic [15:0] p, input logic [3:0] bits, input logic [1:0] pm, input logic sb);
    prescale    = p;
    data_bits   = bits;
    parity_mode = pm;
    stop_bits   = sb;
  endtask

  task automatic popHead();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
  endtask

  task automatic checkHead(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    checkOutput({tag, "_valid"}, 32'(rx_valid), 32'h1);
    checkOutput({tag, "_data"}, 32'(rx_data), 32'(d));
    checkOutput({tag, "_perr"}, 32'(rx_parity_err), 32'(pe));
    checkOutput({tag, "_ferr"}, 32'(rx_frame_err), 32'(fe));
  endtask

  initial begin
    rst          = 1'b1;
    rxd          = 1'b1;
    rx_ready     = 1'b0;
    clear_errors = 1'b0;
    setConfig(16'd16, 4'd8, 2'b00, 1'b0);
    waitCycles(4);
    rst = 1'b0;
    waitCycles(2);

    // Reset state
    checkOutput("rst_valid", 32'(rx_valid), 32'h0);
    checkOutput("rst_data", 32'(rx_data), 32'h0);
    checkOutput("rst_perr", 32'(rx_parity_err), 32'h0);
    checkOutput("rst_ferr", 32'(rx_frame_err), 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_overrun", 32'(overrun_error), 32'h0);
    checkOutput("rst_break", 32'(break_detect), 32'h0);

    // 8N1 at prescale 16: two frames are held in the FIFO, then popped in order.
    applyStimulus(9'h0A5, 8, 0, 1'b0, 1'b1, 1, 16, -1);
    applyStimulus(9'h03C, 8, 0, 1'b0, 1'b1, 1, 16, -1);
    checkOutput("n1_level2", 32'(fifo_level), 32'h2);
    checkHead("n1_a5", 8'hA5, 1'b0, 1'b0);
    popHead();
    checkHead("n1_3c", 8'h3C, 1'b0, 1'b0);
    checkOutput("n1_level1", 32'(fifo_level), 32'h1);
    popHead();
    checkOutput("n1_empty_valid", 32'(rx_valid), 32'h0);
    checkOutput("n1_empty_data", 32'(rx_data), 32'h0);

    // 7E2 at prescale 8: a frame with a wrong parity bit, then a frame whose
    // second stop bit is 0.
    setConfig(16'd8, 4'd7, 2'b01, 1'b1);
    applyStimulus(9'h055, 7, 1, 1'b1, 1'b1, 2, 8, -1);
    checkHead("e2_par", 8'h55, 1'b1, 1'b0);
    popHead();
    applyStimulus(9'h012, 7, 1, 1'b0, 1'b0, 2, 8, -1);
    checkHead("e2_stop2", 8'h12, 1'b0, 1'b1);
    popHead();
    checkOutput("e2_level0", 32'(fifo_level), 32'h0);

    // A single-clock low glitch is a false start.
    setConfig(16'd8, 4'd8, 2'b00, 1'b0);
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    @(negedge clk);
    checkOutput("fs_busy_before", 32'(busy), 32'h0);
    @(negedge clk);
    checkOutput("fs_busy_start", 32'(busy), 32'h1);
    waitCycles(10);
    checkOutput("fs_busy_end", 32'(busy), 32'h0);
    checkOutput("fs_level", 32'(fifo_level), 32'h0);
    checkOutput("fs_break", 32'(break_detect), 32'h0);
    checkOutput("fs_overrun", 32'(overrun_error), 32'h0);

    // A one-sample glitch inside a data bit is outvoted by the other two samples.
    applyStimulus(9'h00F, 8, 0, 1'b0, 1'b1, 1, 8, 3);
    checkHead("gl_one", 8'h0F, 1'b0, 1'b0);
    popHead();
    applyStimulus(9'h00F, 8, 0, 1'b0, 1'b1, 1, 8, 6);
    checkHead("gl_zero", 8'h0F, 1'b0, 1'b0);
    popHead();

    // Break: rxd held low for 12 bit times, then released.
    @(negedge clk); rxd = 1'b0;
    waitCycles(95);
    checkOutput("brk_flag", 32'(break_detect), 32'h1);
    checkOutput("brk_busy_held", 32'(busy), 32'h1);
    checkOutput("brk_level", 32'(fifo_level), 32'h0);
    @(negedge clk); rxd = 1'b1;
    waitCycles(6);
    checkOutput("brk_busy_released", 32'(busy), 32'h0);
    checkOutput("brk_sticky", 32'(break_detect), 32'h1);
    pulseClear();
    checkOutput("brk_cleared", 32'(break_detect), 32'h0);

    // Overrun: five frames without popping. The fifth frame is dropped.
    applyStimulus(9'h011, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h022, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h033, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h044, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h055, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    checkOutput("ov_level", 32'(fifo_level), 32'h4);
    checkOutput("ov_flag", 32'(overrun_error), 32'h1);
    checkHead("ov_h0", 8'h11, 1'b0, 1'b0);
    popHead();
    checkHead("ov_h1", 8'h22, 1'b0, 1'b0);
    popHead();
    checkHead("ov_h2", 8'h33, 1'b0, 1'b0);
    popHead();
    checkHead("ov_h3", 8'h44, 1'b0, 1'b0);
    popHead();
    checkOutput("ov_drained", 32'(fifo_level), 32'h0);
    pulseClear();
    checkOutput("ov_cleared", 32'(overrun_error), 32'h0);

    // Full FIFO with a pop in the same cycle as the push. For 8N1 at prescale 8,
    // counting falling edges from the start bit as 0..79, the push cycle is
    // falling edge 79, so rx_ready is held high for that one cycle.
    applyStimulus(9'h061, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h062, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h063, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    applyStimulus(9'h064, 8, 0, 1'b0, 1'b1, 1, 8, -1);
    checkOutput("op_full", 32'(fifo_level), 32'h4);
    fork
      applyStimulus(9'h065, 8, 0, 1'b0, 1'b1, 1, 8, -1);
      begin
        repeat (80) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    checkOutput("op_level", 32'(fifo_level), 32'h4);
    checkOutput("op_no_overrun", 32'(overrun_error), 32'h0);
    checkHead("op_h0", 8'h62, 1'b0, 1'b0);
    popHead();
    checkHead("op_h1", 8'h63, 1'b0, 1'b0);
    popHead();
    checkHead("op_h2", 8'h64, 1'b0, 1'b0);
    popHead();
    checkHead("op_h3", 8'h65, 1'b0, 1'b0);
    popHead();

    // Changing data_bits mid-frame has no effect until the next frame.
    fork
      applyStimulus(9'h0C3, 8, 0, 1'b0, 1'b1, 1, 8, -1);
      begin
        repeat (30) @(negedge clk);
        data_bits = 4'd5;
      end
    join
    checkHead("db_c3", 8'hC3, 1'b0, 1'b0);
    popHead();
    applyStimulus(9'h01F, 5, 0, 1'b0, 1'b1, 1, 8, -1);
    checkHead("db_1f", 8'h1F, 1'b0, 1'b0);
    popHead();
    checkOutput("db_level0", 32'(fifo_level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
